// File: rtl/video_timing_gen_if.sv
// Video output bundle from the timing generator to the TMDS encoder.
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic [7:0]    red_o;
    logic [7:0]    green_o;
    logic [7:0]    blue_o;
    logic [CW-1:0] counter_x_o;
    logic [CW-1:0] counter_y_o;
    logic          hsync_o;
    logic          vsync_o;
    logic          draw_area_o;
    logic          frame_start_o;
    logic          line_start_o;

    modport master (
        output red_o, green_o, blue_o,
        output counter_x_o, counter_y_o,
        output hsync_o, vsync_o, draw_area_o,
        output frame_start_o, line_start_o
    );

    modport slave (
        input red_o, green_o, blue_o,
        input counter_x_o, counter_y_o,
        input hsync_o, vsync_o, draw_area_o,
        input frame_start_o, line_start_o
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised video timing and test-pattern generator.
// Test patterns are built only when VTG_PATTERN_EN is defined.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [23:0]       solid_rgb,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic [CW-1:0] r_x, r_y;
    logic [CW-1:0] w_x_nxt, w_y_nxt;
    logic          w_x_last, w_y_last;
    logic          w_hs_on, w_vs_on;
    logic          w_draw, w_origin;

    logic [CW-1:0] r_cx, r_cy;
    logic          r_hs, r_vs, r_draw, r_fs, r_ls;

    always_comb begin
        w_x_last = (r_x == CW'(H_TOTAL - 1));
        w_y_last = (r_y == CW'(V_TOTAL - 1));
        w_x_nxt  = r_x + 1'b1;
        w_y_nxt  = r_y;
        if (w_x_last) begin
            w_x_nxt = '0;
            w_y_nxt = w_y_last ? '0 : r_y + 1'b1;
        end
        w_hs_on  = (r_x >= CW'(HS_START)) &&
                   (r_x <= CW'(HS_END));
        w_vs_on  = (r_y >= CW'(VS_START)) &&
                   (r_y <= CW'(VS_END));
        w_draw   = (r_x < CW'(H_ACTIVE)) &&
                   (r_y < CW'(V_ACTIVE));
        w_origin = (r_x == '0) && (r_y == '0);
    end

    // Output stage lags the counters by one en-cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_hs   <= ~HS_POL;
            r_vs   <= ~VS_POL;
            r_draw <= 1'b0;
            r_fs   <= 1'b0;
            r_ls   <= 1'b0;
        end else if (en) begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_cx   <= r_x;
            r_cy   <= r_y;
            r_hs   <= w_hs_on ? HS_POL : ~HS_POL;
            r_vs   <= w_vs_on ? VS_POL : ~VS_POL;
            r_draw <= w_draw;
            r_fs   <= w_origin;
            r_ls   <= (r_x == '0);
        end
    end

    assign vid.counter_x_o   = r_cx;
    assign vid.counter_y_o   = r_cy;
    assign vid.hsync_o       = r_hs;
    assign vid.vsync_o       = r_vs;
    assign vid.draw_area_o   = r_draw;
    assign vid.frame_start_o = r_fs;
    assign vid.line_start_o  = r_ls;

`ifdef VTG_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [1:0]    r_mode, w_mode;
    logic [23:0]   r_solid, w_solid;
    logic [23:0]   r_rgb, w_rgb;
    logic [7:0]    w_x8, w_y8;
    logic [CW-1:0] w_bar;
    logic [2:0]    w_idx;

    always_comb begin
        // Pixel (0,0) already uses the values being latched
        w_mode  = w_origin ? mode : r_mode;
        w_solid = w_origin ? solid_rgb : r_solid;
        w_x8    = 8'(r_x);
        w_y8    = 8'(r_y);
        w_bar   = r_x / CW'(BAR_W);
        w_idx   = (w_bar > CW'(7)) ? 3'd7 : w_bar[2:0];
        w_rgb   = '0;
        unique case (w_mode)
            2'd0: begin
                unique case (w_idx)
                    3'd0: w_rgb = 24'hFFFFFF;
                    3'd1: w_rgb = 24'hFFFF00;
                    3'd2: w_rgb = 24'h00FFFF;
                    3'd3: w_rgb = 24'h00FF00;
                    3'd4: w_rgb = 24'hFF00FF;
                    3'd5: w_rgb = 24'hFF0000;
                    3'd6: w_rgb = 24'h0000FF;
                    3'd7: w_rgb = 24'h000000;
                endcase
            end
            2'd1: w_rgb = (w_x8[5] ^ w_y8[5]) ?
                          24'hFFFFFF : 24'h000000;
            2'd2: w_rgb = {w_x8, w_y8, w_x8 + w_y8};
            2'd3: w_rgb = w_solid;
        endcase
        if (!w_draw) w_rgb = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= 2'd0;
            r_solid <= '0;
            r_rgb   <= '0;
        end else if (en) begin
            if (w_origin) begin
                r_mode  <= mode;
                r_solid <= solid_rgb;
            end
            r_rgb <= w_rgb;
        end
    end

    assign vid.red_o   = r_rgb[23:16];
    assign vid.green_o = r_rgb[15:8];
    assign vid.blue_o  = r_rgb[7:0];
`else
    logic w_unused_pat;
    assign w_unused_pat = ^{mode, solid_rgb};
    assign vid.red_o    = 8'd0;
    assign vid.green_o  = 8'd0;
    assign vid.blue_o   = 8'd0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 80x40 raster.
module tb_video_timing_gen;
    // Raster: 80+4+6+6 = 96 pixels, 40+2+3+3 = 48 lines
    localparam int HT    = 96;
    localparam int FRAME = 4608;
`ifdef VTG_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;

    int n_chk  = 0;
    int n_fail = 0;

    video_timing_gen_if #(.CW(12)) vif ();

    video_timing_gen #(
        .H_ACTIVE(80), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .solid_rgb (solid_rgb),
        .vid       (vif)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] px(input logic [23:0] v);
        return PAT ? v : 24'h000000;
    endfunction

    function automatic logic [23:0] rgb();
        return {vif.red_o, vif.green_o, vif.blue_o};
    endfunction

    function automatic logic [36:0] snap();
        return {vif.counter_x_o, vif.counter_y_o,
                vif.hsync_o, vif.vsync_o, vif.draw_area_o,
                vif.frame_start_o, vif.line_start_o, rgb()};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int x, input int y);
        int n;
        n = 0;
        while (!(vif.counter_x_o == 12'(x) &&
                 vif.counter_y_o == 12'(y)) &&
               n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("goto_reached", 32'(n < 2 * FRAME), 32'd1);
    endtask

    task automatic chk_px(input string tag,
                          input logic [23:0] exp);
        chk(tag, 32'(rgb()), 32'(px(exp)));
    endtask

    int ex, ey, c, period;
    int pos_err, hs_err, vs_err, dr_err, fs_err, ls_err;
    int hs_low, vs_low, hold_err;
    logic [36:0] prev;
    logic        prev_fs;

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        mode = 2'd0;
        solid_rgb = 24'h000000;
        #23;
        chk("rst_x", 32'(vif.counter_x_o), 0);
        chk("rst_y", 32'(vif.counter_y_o), 0);
        chk("rst_hs", 32'(vif.hsync_o), 1);
        chk("rst_vs", 32'(vif.vsync_o), 1);
        chk("rst_draw", 32'(vif.draw_area_o), 0);
        chk("rst_fs", 32'(vif.frame_start_o), 0);
        chk("rst_ls", 32'(vif.line_start_o), 0);
        chk("rst_rgb", 32'(rgb()), 0);

        rst_n = 1'b1;
        tick();
        chk("first_fs", 32'(vif.frame_start_o), 1);
        chk("first_ls", 32'(vif.line_start_o), 1);
        chk("first_draw", 32'(vif.draw_area_o), 1);
        chk_px("bar_x0", 24'hFFFFFF);

        // One full frame of timing in mode 0
        pos_err = 0; hs_err = 0; vs_err = 0; dr_err = 0;
        fs_err = 0; ls_err = 0; hs_low = 0; vs_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            ex = i % HT;
            ey = i / HT;
            if (vif.counter_x_o !== 12'(ex) ||
                vif.counter_y_o !== 12'(ey)) pos_err++;
            if (vif.hsync_o !== !(ex >= 84 && ex <= 89))
                hs_err++;
            if (vif.vsync_o !== !(ey >= 42 && ey <= 44))
                vs_err++;
            if (vif.draw_area_o !== (ex < 80 && ey < 40))
                dr_err++;
            if (vif.frame_start_o !== (i == 0)) fs_err++;
            if (vif.line_start_o !== (ex == 0)) ls_err++;
            if (vif.hsync_o === 1'b0) hs_low++;
            if (vif.vsync_o === 1'b0) vs_low++;
            tick();
        end
        chk("sweep_pos", pos_err, 0);
        chk("sweep_hs", hs_err, 0);
        chk("sweep_vs", vs_err, 0);
        chk("sweep_draw", dr_err, 0);
        chk("sweep_fs", fs_err, 0);
        chk("sweep_ls", ls_err, 0);
        chk("hs_low_cnt", hs_low, 288);
        chk("vs_low_cnt", vs_low, 288);
        chk("frame_period_fs",
            32'(vif.frame_start_o), 1);

        goto(10, 0);  chk_px("bar_yellow", 24'hFFFF00);
        goto(25, 0);  chk_px("bar_cyan", 24'h00FFFF);
        goto(35, 0);  chk_px("bar_green", 24'h00FF00);
        goto(45, 0);  chk_px("bar_magenta", 24'hFF00FF);
        goto(55, 0);  chk_px("bar_red", 24'hFF0000);
        goto(65, 0);  chk_px("bar_blue", 24'h0000FF);
        goto(79, 0);  chk_px("bar_last", 24'h000000);
        chk("draw_x79", 32'(vif.draw_area_o), 1);
        goto(80, 0);  chk("rgb_x80", 32'(rgb()), 0);
        chk("draw_x80", 32'(vif.draw_area_o), 0);

        // Mode change mid-frame must wait for the next frame
        goto(40, 20);
        mode = 2'd3;
        solid_rgb = 24'h123456;
        tick();
        chk_px("latch_mid", 24'hFF00FF);
        goto(0, 30);  chk_px("latch_row30", 24'hFFFFFF);
        goto(0, 0);   chk_px("solid_00", 24'h123456);
        goto(20, 10); chk_px("solid_mid", 24'h123456);
        goto(85, 10); chk("solid_blank", 32'(rgb()), 0);

        mode = 2'd1;
        goto(0, 0);   chk_px("chk_00", 24'h000000);
        goto(32, 0);  chk_px("chk_32_0", 24'hFFFFFF);
        goto(0, 33);  chk_px("chk_0_33", 24'hFFFFFF);
        goto(32, 33); chk_px("chk_32_33", 24'h000000);
        goto(64, 39); chk_px("chk_64_39", 24'hFFFFFF);

        mode = 2'd2;
        goto(0, 0);   chk_px("grad_00", 24'h000000);
        goto(3, 7);   chk_px("grad_3_7", 24'h03070A);
        goto(79, 39); chk_px("grad_79_39", 24'h4F2776);
        goto(79, 40); chk("grad_blank", 32'(rgb()), 0);

        // en toggling every other clock doubles the frame period
        goto(0, 0);
        period = 0;
        hold_err = 0;
        prev_fs = vif.frame_start_o;
        for (int k = 1; k <= 20000; k++) begin
            en = (k % 2 == 0);
            prev = snap();
            tick();
            if (!en && snap() !== prev) hold_err++;
            if (vif.frame_start_o && !prev_fs) begin
                period = k;
                break;
            end
            prev_fs = vif.frame_start_o;
        end
        en = 1'b1;
        chk("en_period", period, 9216);
        chk("en_hold", hold_err, 0);

        // Asynchronous reset in mid-frame
        mode = 2'd0;
        goto(30, 10);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_x", 32'(vif.counter_x_o), 0);
        chk("arst_y", 32'(vif.counter_y_o), 0);
        chk("arst_hs", 32'(vif.hsync_o), 1);
        chk("arst_vs", 32'(vif.vsync_o), 1);
        chk("arst_draw", 32'(vif.draw_area_o), 0);
        chk("arst_fs", 32'(vif.frame_start_o), 0);
        chk("arst_ls", 32'(vif.line_start_o), 0);
        chk("arst_rgb", 32'(rgb()), 0);
        tick();
        chk("arst_hold_x", 32'(vif.counter_x_o), 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("restart_x", 32'(vif.counter_x_o), 0);
        chk("restart_y", 32'(vif.counter_y_o), 0);
        chk("restart_fs", 32'(vif.frame_start_o), 1);
        chk("restart_ls", 32'(vif.line_start_o), 1);
        chk_px("restart_rgb", 24'hFFFFFF);
        tick();
        chk("restart_x1", 32'(vif.counter_x_o), 1);
        chk("restart_fs1", 32'(vif.frame_start_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing and test-pattern generator: the successor of the fixed 640x480 HDMI test block. It produces pixel counters, sync, draw-area and RGB test patterns for any resolution and polarity set at elaboration. It also adds a pixel enable, frame/line start strobes and run-time pattern selection. It sits between the pixel clock domain and the TMDS encoder/serialiser.

## Interface
- H_ACTIVE, 640, visible pixels per line (>= 8)
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels (each >= 1)
- V_ACTIVE, 480, visible lines (>= 1)
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines (each >= 1)
- HS_POL / VS_POL, 0 / 0, asserted level of hsync_o / vsync_o
- CW, 12, counter width; H_TOTAL-1 and V_TOTAL-1 must fit in CW bits
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  pixel enable; the timing advances only when en=1
- mode  in  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
- solid_rgb  in  24  {R,G,B} colour for mode 3
- red_o / green_o / blue_o  out  8 each  pixel colour
- counter_x_o / counter_y_o  out  CW each  pixel position of the current outputs
- hsync_o / vsync_o  out  1 each  sync outputs at the HS_POL / VS_POL level
- draw_area_o  out  1  high when the pixel is visible
- frame_start_o / line_start_o  out  1 each  high for the pixel (0,0) / (0,y)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way from the vertical parameters.
- Internal counters x and y:
  - On each en=1 cycle, x increments.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At y=V_TOTAL-1 together with x wrap, y wraps to 0.
- Horizontal regions: active for x in [0, H_ACTIVE-1], then FP, then sync, then BP.
- Sync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Vertical sync uses the same rule in lines.
- draw_area = (x < H_ACTIVE) && (y < V_ACTIVE).
- Mode handling:
  - mode and solid_rgb are captured into shadow registers only on an en cycle where the internal counters are (0,0).
  - The pattern therefore never changes mid-frame.
  - After reset the shadow values are mode 0 and solid 0.
- Patterns, all computed from x and y:
  - Mode 0, colour bars: BAR_W = H_ACTIVE/8 (integer division). idx = min(x/BAR_W, 7). The colours are white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. The last bar absorbs the remainder of H_ACTIVE.
  - Mode 1, checkerboard: x[5]^y[5] gives 000000 when 0 and FFFFFF when 1, i.e. 32x32 squares starting black.
  - Mode 2, gradient: R=x[7:0], G=y[7:0], B=(x+y) modulo 256.
  - Mode 3: solid_rgb from the shadow register.
- RGB is forced to 0 whenever draw_area is 0.

## Timing
- All outputs are registered and updated only on en=1 cycles. They form one output stage that is coherent with counter_x_o/counter_y_o.
- An output set for position (x,y) appears 1 en-cycle after the internal counters hold (x,y).
- When en=0, the counters, shadow registers and outputs all hold their values.
- Reset (rst_n low) is asynchronous and takes effect immediately, including in mid-frame:
  - internal x,y = 0
  - counter_x_o = counter_y_o = 0
  - hsync_o = ~HS_POL, vsync_o = ~VS_POL
  - draw_area_o = 0, frame_start_o = 0, line_start_o = 0
  - RGB = 0
- First en cycle after reset release: outputs show (0,0) with draw_area_o=1, frame_start_o=1 and line_start_o=1.
- frame_start_o and line_start_o are high for exactly one en cycle. The next frame_start_o follows H_TOTAL*V_TOTAL en-cycles later.
- Wrap condition: x and y both wrap on the same en cycle at (H_TOTAL-1, V_TOTAL-1).

## Configuration
- VTG_PATTERN_EN defined: the pattern logic, shadow registers and mode/solid_rgb inputs are active as described above.
- VTG_PATTERN_EN undefined:
  - The pattern logic is removed and mode/solid_rgb are ignored.
  - red_o, green_o and blue_o are constant 0.
  - All timing outputs are unchanged.

## Test plan
All scenarios use default parameters, en=1 and VTG_PATTERN_EN defined unless stated otherwise.
- hsync: per line, hsync_o=0 exactly for counter_x_o 656..751 (96 cycles) and =1 elsewhere. The line period is 800 cycles.
- vsync: vsync_o=0 exactly for counter_y_o 490..491 (1600 cycles) and =1 elsewhere. frame_start_o pulses every 420000 cycles.
- Colour bars (mode 0), line 0:
  - x=0 gives FFFFFF; x=80 gives FFFF00; x=639 gives 000000 with draw_area_o=1.
  - x=640 gives RGB 0 with draw_area_o=0.
- Mode latching: switch mode 0->3 with solid_rgb=123456 at (320,200). The remainder of that frame stays as bars; (0,0) of the next frame shows 123456.
- Enable and reset:
  - en toggling every other cycle: the frame period becomes 840000 clk cycles and outputs hold while en=0.
  - rst_n pulled low at (300,100): all outputs take their reset values asynchronously.
  - Restart after release: outputs restart from (0,0) with frame_start_o=1.
- Without VTG_PATTERN_EN: RGB stays 000000 in every mode while hsync/vsync timing matches the first two scenarios.
